beat_sequencer: RTL and testbench

//  Run/step sequencer for the model computer. Generates the one-hot beat ring T0..T7 that feeds control.

---
 rtl/beat_sequencer_pkg.sv | 36 +++
 rtl/beat_sequencer_if.sv | 30 +++
 rtl/beat_sequencer_beat_ring.sv | 35 +++
 rtl/beat_sequencer.sv | 143 ++++++++++++++
 tb/tb_beat_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/beat_sequencer_pkg.sv
// rtl/beat_sequencer_pkg.sv - shared model-computer constants: states, opcodes, decode bits
package beat_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_PAUSE  = 2'd2;
  localparam state_t ST_HALTED = 2'd3;

  localparam int unsigned OP_LD   = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_AND  = 3;
  localparam int unsigned OP_OR   = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_SHL  = 6;
  localparam int unsigned OP_HALT = 7;

  // op_dec bit positions line up with the opcode values
  localparam int DEC_LD   = 0;
  localparam int DEC_HALT = 7;
  localparam int DEC_W    = 8;

  // last fetch beat; the opcode is captured on the edge that ends it
  localparam int FETCH_LAST = 2;

  // one-hot instruction line for a legal opcode, all-zero for anything else
  function automatic logic [DEC_W-1:0] decode_op(input int unsigned op);
    logic [DEC_W-1:0] dec;
    dec = '0;
    if (op <= OP_HALT) dec[op[2:0]] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// rtl/beat_sequencer_if.sv - front-panel/IR inputs and beat/decode outputs of the sequencer
interface beat_sequencer_if
  import beat_sequencer_pkg::*;
#(
  parameter int BEATS = 8,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             step_mode;
  logic             step;
  logic [OP_W-1:0]  ir_op;
  logic [BEATS-1:0] t_beat;
  logic [DEC_W-1:0] op_dec;
  logic             running;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, stop, step_mode, step, ir_op,
    input  t_beat, op_dec, running, halted, illegal, instr_cnt
  );

  modport slave (
    input  start, stop, step_mode, step, ir_op,
    output t_beat, op_dec, running, halted, illegal, instr_cnt
  );
endinterface

// File: rtl/beat_sequencer_beat_ring.sv
// rtl/beat_sequencer_beat_ring.sv - one-hot beat shift ring with clear/load/advance
module beat_sequencer_beat_ring
  import beat_sequencer_pkg::*;
#(
  parameter int BEATS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  output logic [BEATS-1:0] beat,
  output logic             fetch_last,
  output logic             exec_first,
  output logic             last
);

  // ring is all-zero while stopped, loads T0 on (re)start, rotates while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (load) begin
      beat <= BEATS'(1);
    end else if (en) begin
      beat <= {beat[BEATS-2:0], beat[BEATS-1]};
    end
  end

  assign fetch_last = beat[FETCH_LAST];
  assign exec_first = beat[FETCH_LAST+1];
  assign last       = beat[BEATS-1];

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - run/step/halt sequencer producing beat ring and decoded opcode lines
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int BEATS = 8,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  beat_sequencer_if.slave  bus
);

  state_t           state;
  state_t           state_nx;
  logic [BEATS-1:0] beat;
  logic             fetch_last;
  logic             exec_first;
  logic             last_beat;
  logic             ring_clear;
  logic             ring_load;
  logic             ring_en;
  logic [OP_W-1:0]  op;
  logic [DEC_W-1:0] op_dec;
  logic             illegal;
  logic             stop_pend;
  logic [CNT_W-1:0] cnt;
  logic             op_illegal;
  logic             halt_now;
  logic             retire;
  logic             start_ok;
  logic             latch_op;

  beat_sequencer_beat_ring #(.BEATS(BEATS)) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (ring_clear),
    .load       (ring_load),
    .en         (ring_en),
    .beat       (beat),
    .fetch_last (fetch_last),
    .exec_first (exec_first),
    .last       (last_beat)
  );

  assign op_illegal = (32'(op) > OP_HALT);
  // HALT and illegal opcodes both stop at the end of the first execute beat
  assign halt_now   = (state == ST_RUN) && exec_first && (32'(op) >= OP_HALT);
  assign retire     = (state == ST_RUN) && last_beat && !halt_now;
  assign start_ok   = ((state == ST_IDLE) || (state == ST_HALTED)) && bus.start;
  assign latch_op   = (state == ST_RUN) && fetch_last;

  // next-state and beat-ring control
  always_comb begin
    state_nx   = state;
    ring_clear = 1'b0;
    ring_load  = 1'b0;
    ring_en    = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_nx  = ST_RUN;
          ring_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_now) begin
          state_nx   = ST_HALTED;
          ring_clear = 1'b1;
        end else if (last_beat) begin
          // a stop arriving on the final beat still counts as seen during this instruction
          if (stop_pend || bus.stop) begin
            state_nx   = ST_HALTED;
            ring_clear = 1'b1;
          end else if (bus.step_mode) begin
            state_nx   = ST_PAUSE;
            ring_clear = 1'b1;
          end else begin
            ring_en = 1'b1;
          end
        end else begin
          ring_en = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_nx = ST_HALTED;
        end else if (bus.step || !bus.step_mode) begin
          state_nx  = ST_RUN;
          ring_load = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // opcode latch and registered decode; decode is held through the execute beats only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      op_dec <= '0;
    end else if (latch_op) begin
      op     <= bus.ir_op;
      op_dec <= decode_op(32'(bus.ir_op));
    end else if (halt_now || retire) begin
      op_dec <= '0;
    end
  end

  // sticky illegal flag: set by an illegal halt, cleared by the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       illegal <= 1'b0;
    else if (start_ok)                illegal <= 1'b0;
    else if (halt_now && op_illegal)  illegal <= 1'b1;
  end

  // pending stop remembered across the instruction, dropped once halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stop_pend <= 1'b0;
    else if (state_nx == ST_HALTED)            stop_pend <= 1'b0;
    else if ((state == ST_RUN) && bus.stop)    stop_pend <= 1'b1;
  end

  // retired-instruction counter; HALT counts, aborted instructions do not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (halt_now || retire) cnt <= cnt + CNT_W'(1);
  end

  assign bus.t_beat    = beat;
  assign bus.op_dec    = op_dec;
  assign bus.running   = (state == ST_RUN);
  assign bus.halted    = (state == ST_HALTED);
  assign bus.illegal   = illegal;
  assign bus.instr_cnt = cnt;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - directed and random checks of beat_sequencer against a behavioural model
module tb_beat_sequencer;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_HALTED = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] ir_op = 4'd0;

  int checks = 0;
  int errors = 0;

  int m_mode = M_IDLE;
  int m_beat = 0;
  int m_op   = 0;
  int m_cnt  = 0;
  bit m_ill  = 1'b0;
  bit m_pend = 1'b0;

  beat_sequencer_if #(.BEATS(8), .OP_W(4), .CNT_W(16)) bus_a ();
  beat_sequencer_if #(.BEATS(8), .OP_W(4), .CNT_W(2))  bus_b ();

  assign bus_a.start     = start;
  assign bus_a.stop      = stop;
  assign bus_a.step_mode = step_mode;
  assign bus_a.step      = step;
  assign bus_a.ir_op     = ir_op;
  assign bus_b.start     = start;
  assign bus_b.stop      = stop;
  assign bus_b.step_mode = step_mode;
  assign bus_b.step      = step;
  assign bus_b.ir_op     = ir_op;

  beat_sequencer #(.BEATS(8), .OP_W(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  beat_sequencer #(.BEATS(8), .OP_W(4), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_beat = 0;
    m_op   = 0;
    m_cnt  = 0;
    m_ill  = 1'b0;
    m_pend = 1'b0;
  endtask

  // what one clock edge does, given the inputs currently applied
  task automatic model_step();
    if (!rst_n) return;
    case (m_mode)
      M_IDLE, M_HALTED: begin
        if (start) begin
          m_mode = M_RUN;
          m_beat = 0;
          m_ill  = 1'b0;
        end
      end
      M_RUN: begin
        if (stop) m_pend = 1'b1;
        if (m_beat == 2) m_op = int'(ir_op);
        if (m_beat == 3 && m_op >= 7) begin
          if (m_op > 7) m_ill = 1'b1;
          m_cnt++;
          m_mode = M_HALTED;
          m_pend = 1'b0;
        end else if (m_beat == 7) begin
          m_cnt++;
          if (m_pend) begin
            m_mode = M_HALTED;
            m_pend = 1'b0;
          end else if (step_mode) begin
            m_mode = M_PAUSE;
          end else begin
            m_beat = 0;
          end
        end else begin
          m_beat++;
        end
      end
      default: begin
        if (stop) m_mode = M_HALTED;
        else if (step || !step_mode) begin
          m_mode = M_RUN;
          m_beat = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    logic [7:0] et;
    logic [7:0] ed;
    et = (m_mode == M_RUN) ? 8'(1 << m_beat) : 8'h00;
    ed = (m_mode == M_RUN && m_beat >= 3 && m_op <= 7) ? 8'(1 << m_op) : 8'h00;
    chk("t_beat",    32'(bus_a.t_beat),    32'(et));
    chk("op_dec",    32'(bus_a.op_dec),    32'(ed));
    chk("running",   32'(bus_a.running),   32'(m_mode == M_RUN));
    chk("halted",    32'(bus_a.halted),    32'(m_mode == M_HALTED));
    chk("illegal",   32'(bus_a.illegal),   32'(m_ill));
    chk("instr_cnt", 32'(bus_a.instr_cnt), 32'(m_cnt % 65536));
    chk("cnt_w2",    32'(bus_b.instr_cnt), 32'(m_cnt % 4));
    chk("t_beat_b",  32'(bus_b.t_beat),    32'(et));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    check_all();

    // 1: ADD walks the full ring, decode only in execute beats
    ir_op = 4'd1;
    pulse_start();
    chk("t1_t0", 32'(bus_a.t_beat), 32'h01);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("t1_ring", 32'(bus_a.t_beat), 32'(1 << k));
      chk("t1_dec", 32'(bus_a.op_dec), (k >= 3) ? 32'h02 : 32'h00);
    end
    tick();
    chk("t1_cnt", 32'(bus_a.instr_cnt), 32'd1);

    // 2: LD, SUB, HALT
    ir_op = 4'd0;
    ticks(3);
    chk("t2_ld", 32'(bus_a.op_dec), 32'h01);
    ticks(5);
    ir_op = 4'd2;
    ticks(3);
    chk("t2_sub", 32'(bus_a.op_dec), 32'h04);
    ticks(5);
    ir_op = 4'd7;
    ticks(3);
    chk("t2_halt_dec", 32'(bus_a.op_dec), 32'h80);
    tick();
    chk("t2_halted", 32'(bus_a.halted), 32'd1);
    chk("t2_beat0", 32'(bus_a.t_beat), 32'd0);
    chk("t2_cnt", 32'(bus_a.instr_cnt), 32'd4);

    // 3: single-step
    step_mode = 1'b1;
    ir_op = 4'd3;
    pulse_start();
    ticks(8);
    chk("t3_pause", 32'(bus_a.t_beat), 32'd0);
    ticks(3);
    step = 1'b1;
    tick();
    step = 1'b1;
    ticks(3);
    step = 1'b0;
    ticks(5);
    chk("t3_pause2", 32'(bus_a.running), 32'd0);
    chk("t3_cnt", 32'(bus_a.instr_cnt), 32'd6);

    // 4: stop at T1 of XOR, resume free-run from pause
    ir_op = 4'd5;
    step_mode = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ticks(5);
    chk("t4_t7", 32'(bus_a.t_beat), 32'h80);
    tick();
    chk("t4_halted", 32'(bus_a.halted), 32'd1);
    pulse_start();
    chk("t4_restart", 32'(bus_a.t_beat), 32'h01);

    // 5: illegal opcode
    ir_op = 4'd9;
    ticks(3);
    chk("t5_dec", 32'(bus_a.op_dec), 32'h00);
    tick();
    chk("t5_illegal", 32'(bus_a.illegal), 32'd1);
    chk("t5_halted", 32'(bus_a.halted), 32'd1);
    ir_op = 4'd1;
    pulse_start();
    chk("t5_clear", 32'(bus_a.illegal), 32'd0);

    // 6: async reset at T5, then counter wrap on the narrow instance
    ticks(5);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_cnt", 32'(bus_a.instr_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    pulse_start();
    ticks(40);
    chk("t6_wrap", 32'(bus_b.instr_cnt), 32'd1);

    // random free-run with panel controls
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      step  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) step_mode = ~step_mode;
      ir_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
